// File: rtl/mips_pkg.sv
// mips_pkg: load-type codes shared between the MEM/WB stage and its load aligner
package mips_pkg;
  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LB  = 3'b001,
    LT_LBU = 3'b010,
    LT_LH  = 3'b011,
    LT_LHU = 3'b100
  } load_type_e;
endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: extracts and extends the byte/halfword a load selects from the read word
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  // pick the addressed lane, then extend by load type; unknown codes behave as lw
  always_comb begin
    w_byte = rdata[{addr, 3'b000} +: 8];
    w_half = rdata[{addr[1], 4'b0000} +: 16];
    data   = load_type == LT_LB  ? {{24{w_byte[7]}}, w_byte} :
             load_type == LT_LBU ? {24'd0, w_byte} :
             load_type == LT_LH  ? {{16{w_half[15]}}, w_half} :
             load_type == LT_LHU ? {16'd0, w_half} : rdata;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register with writeback data selection; SUBWORD_LOAD_EN enables lb/lbu/lh/lhu alignment
module mem_wb_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_regwrite,
  input  logic        mem_memtoreg,
  input  logic [4:0]  mem_dest,
  input  logic [31:0] mem_alu_result,
  input  logic [2:0]  mem_load_type,
  input  logic [31:0] mem_rdata,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] WBpc,
  output logic        WB_regwrite,
  output logic [4:0]  WB_dest,
  output logic [31:0] WB_wdata,
  output logic        wb_valid,
  output logic        wb_fwd_en
);
  logic        r_valid, r_regwrite, r_memtoreg;
  logic [31:0] r_pc, r_alu_result, r_rdata;
  logic [4:0]  r_dest;
  logic [31:0] w_load_data;
  // pipeline register: reset clears, flush only kills validity, stall holds everything
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_regwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_dest       <= '0;
      r_alu_result <= '0;
      r_rdata      <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_valid      <= mem_valid;
      r_pc         <= mem_pc;
      r_regwrite   <= mem_regwrite;
      r_memtoreg   <= mem_memtoreg;
      r_dest       <= mem_dest;
      r_alu_result <= mem_alu_result;
      r_rdata      <= mem_rdata;
    end
  end
`ifdef SUBWORD_LOAD_EN
  logic [2:0] r_load_type;
  // load type follows the same update rules as the rest of the stage
  always_ff @(posedge clk) begin
    if (!reset) r_load_type <= LT_LW;
    else if (!flush && !stall) r_load_type <= mem_load_type;
  end
  load_align u_load_align (
    .rdata    (r_rdata),
    .addr     (r_alu_result[1:0]),
    .load_type(r_load_type),
    .data     (w_load_data)
  );
`else
  logic w_unused_load_type;
  assign w_unused_load_type = ^mem_load_type;
  assign w_load_data = r_rdata;
`endif
  assign wb_valid    = r_valid;
  assign WBpc        = r_pc;
  assign WB_dest     = r_dest;
  assign WB_regwrite = r_valid & r_regwrite & (|r_dest);
  assign WB_wdata    = r_memtoreg ? w_load_data : r_alu_result;
  assign wb_fwd_en   = WB_regwrite;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed and randomised checks of mem_wb_stage against a behavioural model
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        reset, mem_valid, mem_regwrite, mem_memtoreg, stall, flush;
  logic [31:0] mem_pc, mem_alu_result, mem_rdata;
  logic [4:0]  mem_dest;
  logic [2:0]  mem_load_type;
  logic [31:0] WBpc, WB_wdata;
  logic        WB_regwrite, wb_valid, wb_fwd_en;
  logic [4:0]  WB_dest;
  int n_tests = 0, n_fail = 0;
  bit started = 0;
  logic        m_valid, m_rw, m_mtr;
  logic [31:0] m_pc, m_alu, m_rdata;
  logic [4:0]  m_dest;
  logic [2:0]  m_lt;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_dest(mem_dest),
    .mem_alu_result(mem_alu_result), .mem_load_type(mem_load_type), .mem_rdata(mem_rdata),
    .stall(stall), .flush(flush), .WBpc(WBpc), .WB_regwrite(WB_regwrite),
    .WB_dest(WB_dest), .WB_wdata(WB_wdata), .wb_valid(wb_valid), .wb_fwd_en(wb_fwd_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_wdata();
    logic [31:0] b, h;
    if (!m_mtr) return m_alu;
`ifdef SUBWORD_LOAD_EN
    b = m_rdata >> (8 * m_alu[1:0]);
    h = m_alu[1] ? m_rdata >> 16 : m_rdata;
    case (m_lt)
      3'd1: return 32'($signed(b[7:0]));
      3'd2: return b & 32'hFF;
      3'd3: return 32'($signed(h[15:0]));
      3'd4: return h & 32'hFFFF;
      default: return m_rdata;
    endcase
`else
    b = 0; h = 0;
    return m_rdata + b + h;
`endif
  endfunction

  function automatic logic model_rw();
    return m_valid && m_rw && m_dest != 0;
  endfunction

  // one clock: the model records what the stage must hold after this edge
  task automatic cyc();
    @(posedge clk);
    if (!reset) begin
      {m_valid, m_rw, m_mtr, m_pc, m_alu, m_rdata, m_dest, m_lt} = '0;
    end else if (flush) begin
      m_valid = 0;
    end else if (!stall) begin
      m_valid = mem_valid; m_rw = mem_regwrite; m_mtr = mem_memtoreg; m_pc = mem_pc;
      m_alu = mem_alu_result; m_rdata = mem_rdata; m_dest = mem_dest; m_lt = mem_load_type;
    end
    started = 1;
    #1;
  endtask

  always @(negedge clk) if (started) begin
    chk("cmp_wbpc", WBpc, m_pc);
    chk("cmp_valid", 32'(wb_valid), 32'(m_valid));
    chk("cmp_regwrite", 32'(WB_regwrite), 32'(model_rw()));
    chk("cmp_fwd", 32'(wb_fwd_en), 32'(model_rw()));
    chk("cmp_dest", 32'(WB_dest), 32'(m_dest));
    chk("cmp_wdata", WB_wdata, model_wdata());
  end

  task automatic issue(input logic [31:0] pc, input logic rw, input logic mtr, input logic [4:0] d,
                       input logic [31:0] alu, input logic [2:0] lt, input logic [31:0] rd);
    mem_valid = 1; mem_pc = pc; mem_regwrite = rw; mem_memtoreg = mtr; mem_dest = d;
    mem_alu_result = alu; mem_load_type = lt; mem_rdata = rd;
    cyc();
  endtask

  function automatic logic [31:0] sub(input logic [31:0] sw, input logic [31:0] word);
`ifdef SUBWORD_LOAD_EN
    return sw | (word & 32'h0);
`else
    return word | (sw & 32'h0);
`endif
  endfunction

  initial begin
    reset = 0; stall = 0; flush = 0; mem_valid = 1; mem_pc = 32'hFFFFFFFF; mem_regwrite = 1;
    mem_memtoreg = 1; mem_dest = 5'd9; mem_alu_result = 32'hFFFFFFFF; mem_load_type = 0;
    mem_rdata = 32'hFFFFFFFF;
    cyc(); cyc();
    chk("rst_wbpc", WBpc, 32'h0);
    chk("rst_regwrite", 32'(WB_regwrite), 32'h0);
    chk("rst_valid", 32'(wb_valid), 32'h0);
    chk("rst_fwd", 32'(wb_fwd_en), 32'h0);
    reset = 1;
    issue(32'h00400000, 1, 1, 5'd5, 32'h00001000, 3'd0, 32'h12345678);
    chk("lw_wdata", WB_wdata, 32'h12345678);
    chk("lw_regwrite", 32'(WB_regwrite), 32'h1);
    chk("lw_dest", 32'(WB_dest), 32'd5);
    issue(32'h00400004, 1, 1, 5'd6, 32'h00001002, 3'd1, 32'h80FF7F01);
    chk("lb_a2", WB_wdata, sub(32'hFFFFFFFF, 32'h80FF7F01));
    issue(32'h00400008, 1, 1, 5'd6, 32'h00001002, 3'd2, 32'h80FF7F01);
    chk("lbu_a2", WB_wdata, sub(32'h000000FF, 32'h80FF7F01));
    issue(32'h0040000C, 1, 1, 5'd6, 32'h00001003, 3'd1, 32'h80FF7F01);
    chk("lb_a3", WB_wdata, sub(32'hFFFFFF80, 32'h80FF7F01));
    issue(32'h00400010, 1, 1, 5'd7, 32'h00002002, 3'd3, 32'h8001ABCD);
    chk("lh_a2", WB_wdata, sub(32'hFFFF8001, 32'h8001ABCD));
    issue(32'h00400014, 1, 1, 5'd7, 32'h00002002, 3'd4, 32'h8001ABCD);
    chk("lhu_a2", WB_wdata, sub(32'h00008001, 32'h8001ABCD));
    issue(32'h00400018, 1, 1, 5'd7, 32'h00002003, 3'd3, 32'h8001ABCD);
    chk("lh_a3", WB_wdata, sub(32'hFFFF8001, 32'h8001ABCD));
    issue(32'h0040001C, 1, 1, 5'd7, 32'h00002003, 3'd4, 32'h8001ABCD);
    chk("lhu_a3", WB_wdata, sub(32'h00008001, 32'h8001ABCD));
    issue(32'h00400020, 1, 1, 5'd8, 32'h00003001, 3'd5, 32'hCAFEF00D);
    chk("lt_other", WB_wdata, 32'hCAFEF00D);
    issue(32'h00400024, 1, 0, 5'd8, 32'hDEADBEEF, 3'd1, 32'h11111111);
    chk("alu_path", WB_wdata, 32'hDEADBEEF);
    issue(32'h00400010, 1, 0, 5'd10, 32'h0000ABCD, 3'd0, 32'h0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      issue(32'h00400020 + 32'(i), 1, 1, 5'd11, 32'h5555_0000, 3'd2, 32'h77777777);
      chk("stall_pc", WBpc, 32'h00400010);
      chk("stall_wdata", WB_wdata, 32'h0000ABCD);
      chk("stall_dest", 32'(WB_dest), 32'd10);
    end
    stall = 0;
    issue(32'h00400030, 1, 0, 5'd12, 32'h00000042, 3'd0, 32'h0);
    chk("post_stall_pc", WBpc, 32'h00400030);
    stall = 1; flush = 1;
    issue(32'h00400040, 1, 0, 5'd13, 32'h00000043, 3'd0, 32'h0);
    chk("flush_valid", 32'(wb_valid), 32'h0);
    chk("flush_regwrite", 32'(WB_regwrite), 32'h0);
    chk("flush_pc_hold", WBpc, 32'h00400030);
    stall = 0; flush = 0;
    issue(32'h00400044, 1, 0, 5'd0, 32'h00000044, 3'd0, 32'h0);
    chk("dest0_regwrite", 32'(WB_regwrite), 32'h0);
    chk("dest0_valid", 32'(wb_valid), 32'h1);
    mem_valid = 0; mem_regwrite = 1; mem_dest = 5'd3; mem_pc = 32'h00400048;
    cyc();
    chk("inv_valid", 32'(wb_valid), 32'h0);
    chk("inv_regwrite", 32'(WB_regwrite), 32'h0);
    issue(32'h00400100, 1, 1, 5'd14, 32'h00000100, 3'd0, 32'hABCDEF01);
    stall = 1;
    issue(32'h00400104, 1, 1, 5'd15, 32'h00000104, 3'd0, 32'h0);
    reset = 0;
    issue(32'h00400108, 1, 1, 5'd15, 32'h00000108, 3'd0, 32'h1);
    chk("rst_stall_pc", WBpc, 32'h0);
    chk("rst_stall_valid", 32'(wb_valid), 32'h0);
    chk("rst_stall_wdata", WB_wdata, 32'h0);
    chk("rst_stall_dest", 32'(WB_dest), 32'h0);
    reset = 1;
    issue(32'h0040010C, 1, 1, 5'd15, 32'h0000010C, 3'd0, 32'h2);
    chk("resume_empty", 32'(wb_valid), 32'h0);
    stall = 0;
    issue(32'h00400200, 1, 0, 5'd16, 32'h00000200, 3'd0, 32'h0);
    chk("resume_pc", WBpc, 32'h00400200);
    chk("resume_valid", 32'(wb_valid), 32'h1);
    for (int i = 0; i < 60; i++) begin
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);
      reset = ($urandom_range(0, 15) != 0);
      mem_valid = 1'($urandom);
      issue($urandom, 1'($urandom), 1'($urandom), 5'($urandom), $urandom,
            3'($urandom_range(0, 7)), $urandom);
      mem_valid = 1'($urandom);
    end
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
